pipelined_shifter: RTL
======================

Name: pipelined_shifter

Overview:
- Parametrised, pipelined successor to the CPU31 combinational barrel shifter.
- Supports SRA/SRL/SLL plus rotate-right/rotate-left, at any power-of-two WIDTH.
- The log2(WIDTH) shift levels are split across PIPE_STAGES register stages.
- Valid/ready handshake on input and output; defined carry/zero flags. Used by the ALU's multi-cycle execute path and the crypto/bitfield helpers.

Parameters:
- WIDTH, 32, data width; power of two, ≥ 8.
- PIPE_STAGES, 2, number of register stages; 1 ≤ PIPE_STAGES ≤ SHW.
- SHW (localparam), $clog2(WIDTH), shift-amount width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline kill.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept.
- in_data  in  WIDTH  operand to shift (B).
- in_shamt  in  SHW  shift amount (A).
- in_mode  in  3  operation select.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_data  out  WIDTH  result.
- out_carry  out  1  last bit shifted out.
- out_zero  out  1  out_data == 0.

Behaviour:
- Mode encoding (low 2 bits match the predecessor's ALUC):
  - 000 SRA; 001 SRL; 010 SLL; 011 SLL.
  - 100 ROR; 101 ROL.
  - 110 and 111 behave as SLL.
- Reset (rst_n low, asynchronous): all stage valid bits 0; out_valid=0, out_data=0, out_carry=0, out_zero=0. Internal datapath registers also clear to 0.
- Level partitioning: shift level k (shift by 2^k, k = 0..SHW-1) is computed in stage floor(k*PIPE_STAGES/SHW). Each stage registers data, remaining shamt, mode, carry and valid.
- Latency: exactly PIPE_STAGES cycles from the accepting edge to out_valid=1 when there is no backpressure. Throughput: 1 op/cycle.
- Handshake:
  - Transfer in: in_valid && in_ready at a rising edge.
  - Transfer out: out_valid && out_ready.
  - Stage i advances when its successor is empty or advancing. The last stage advances on out_ready.
  - in_ready = !valid[0] || advance[0]. It is combinational from out_ready; no combinational in_valid→in_ready path.
  - out_data, out_carry and out_zero hold stable while out_valid && !out_ready.
- Shift semantics:
  - SRA: arithmetic, fills with bit WIDTH-1.
  - SRL: zero fill.
  - SLL: zero fill.
  - ROR/ROL: rotate; no bits lost.
- Carry, per level that shifts by s:
  - Right shifts: carry := data_in_level[s-1].
  - Left shifts: carry := data_in_level[WIDTH-s].
  - The last applied level wins, so the final carry is B[A-1] (right) or B[WIDTH-A] (left).
  - ROR: out_carry = result[WIDTH-1]. ROL: out_carry = result[0].
  - shamt = 0: out_carry = 0, always defined (never X); out_data = in_data.
- out_zero is computed in the last stage from the final data.
- flush:
  - Clears every stage valid bit at the next edge; in_ready=0 while flush=1.
  - An input presented during flush is not accepted.
  - Flush has priority over out_ready; a result dropped by flush is never reported as transferred.
- Reset mid-operation: all in-flight ops are lost; no output pulses after rst_n rises until new input is accepted.
- No X propagation: illegal modes map to SLL.

Decomposition:
- Shared package shifter_pkg:
  - Mode localparams: MODE_SRA=3'b000, MODE_SRL=3'b001, MODE_SLL=3'b010, MODE_ROR=3'b100, MODE_ROL=3'b101.
  - Stage-assignment function stage_of_level(k, SHW, PIPE_STAGES).
- One natural sub-module, shift_level: a combinational single-level shift by 2^k.
  - Inputs: data, enable bit, mode, carry_in. Outputs: data_out, carry_out.
  - Instantiated SHW times by a generate loop; register slices are inserted per the stage map.

Test Plan:
- WIDTH=32, PIPE_STAGES=2; SRA of 0x80000010 by 4, out_ready=1 → out_valid exactly 2 cycles after accept; out_data=0xF8000001, out_carry=0 (bit 3 of input), out_zero=0.
- SLL of 0x00000001 by 31, then SRL of 0x00000001 by 1, back-to-back → 0x80000000 with carry 0, then 0x00000000 with carry 1 and zero 1, on consecutive cycles.
- ROR of 0x00000001 by 1 → 0x80000000, carry 1. ROL of 0x80000000 by 1 → 0x00000001, carry 1. Any op with shamt 0 on 0x12345678 → data unchanged, carry 0.
- Backpressure: issue 4 ops with out_ready=0 → in_ready drops after 2 accepts, out_data holds. Then raise out_ready → results come out in order, none lost or duplicated.
- Flush with 2 ops in flight and in_valid=1 → no out_valid in the following cycles; input not accepted; next op completes with normal latency.
- Async reset asserted mid-stream (between clock edges) → out_valid=0 and out_data=0 immediately. Repeat with WIDTH=16, PIPE_STAGES=4 to check latency 4 and SRA 0x8000 by 15 = 0xFFFF.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared mode encoding and stage-assignment helpers for the pipelined shifter.
package shifter_pkg;

   localparam logic [2:0] MODE_SRA = 3'b000;
   localparam logic [2:0] MODE_SRL = 3'b001;
   localparam logic [2:0] MODE_SLL = 3'b010;
   localparam logic [2:0] MODE_ROR = 3'b100;
   localparam logic [2:0] MODE_ROL = 3'b101;

   function automatic int stage_of_level(input int k, input int shw, input int stages);
      return (k * stages) / shw;
   endfunction

   // Unused encodings collapse onto SLL so nothing downstream sees an undefined mode.
   function automatic logic [2:0] norm_mode(input logic [2:0] mode);
      case (mode)
         MODE_SRA, MODE_SRL, MODE_ROR, MODE_ROL: return mode;
         default:                                return MODE_SLL;
      endcase
   endfunction

endpackage

// File: rtl/shift_level.sv
// One barrel-shifter level: conditionally shifts or rotates by 2^K and updates the carry.
module shift_level
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int K     = 0
) (
   input  logic [WIDTH-1:0] data_in,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             carry_in,
   output logic [WIDTH-1:0] data_out,
   output logic             carry_out
);

   localparam int S = 1 << K;

   logic signed [WIDTH-1:0] data_s;
   logic        [WIDTH-1:0] shifted;
   logic                    cbit;

   assign data_s = $signed(data_in);

   // Rotates report the bit that lands at the wrapped end, which equals the bit shifted out.
   always_comb begin
      shifted = data_in << S;
      cbit    = data_in[WIDTH-S];
      case (mode)
         MODE_SRA: begin
            shifted = $unsigned(data_s >>> S);
            cbit    = data_in[S-1];
         end
         MODE_SRL: begin
            shifted = data_in >> S;
            cbit    = data_in[S-1];
         end
         MODE_ROR: begin
            shifted = (data_in >> S) | (data_in << (WIDTH - S));
            cbit    = data_in[S-1];
         end
         MODE_ROL: begin
            shifted = (data_in << S) | (data_in >> (WIDTH - S));
            cbit    = data_in[WIDTH-S];
         end
         default: begin
            shifted = data_in << S;
            cbit    = data_in[WIDTH-S];
         end
      endcase
      data_out  = en ? shifted : data_in;
      carry_out = en ? cbit : carry_in;
   end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: log2(WIDTH) levels spread over PIPE_STAGES registered stages
// with valid/ready flow control, flush, and carry/zero flags.
module pipelined_shifter
   import shifter_pkg::*;
#(
   parameter  int WIDTH       = 32,
   parameter  int PIPE_STAGES = 2,
   localparam int SHW         = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_shamt,
   input  logic [2:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_carry,
   output logic             out_zero
);

   logic [WIDTH-1:0] data_q  [PIPE_STAGES];
   logic [WIDTH-1:0] data_d  [PIPE_STAGES];
   logic [SHW-1:0]   shamt_q [PIPE_STAGES];
   logic [SHW-1:0]   shamt_d [PIPE_STAGES];
   logic [2:0]       mode_q  [PIPE_STAGES];
   logic [2:0]       mode_d  [PIPE_STAGES];
   logic             carry_q [PIPE_STAGES];
   logic             carry_d [PIPE_STAGES];
   logic [PIPE_STAGES-1:0] valid_q, valid_d, valid_up, load;
   logic             zero_q, zero_d;

   logic [WIDTH-1:0] st_in_data   [PIPE_STAGES];
   logic [SHW-1:0]   st_in_shamt  [PIPE_STAGES];
   logic [2:0]       st_in_mode   [PIPE_STAGES];
   logic             st_in_carry  [PIPE_STAGES];
   logic [WIDTH-1:0] st_out_data  [PIPE_STAGES];
   logic             st_out_carry [PIPE_STAGES];

   logic [WIDTH-1:0] lvl_in_data   [SHW];
   logic             lvl_in_carry  [SHW];
   logic [WIDTH-1:0] lvl_out_data  [SHW];
   logic             lvl_out_carry [SHW];

   for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage_in
      if (s == 0) begin : g_first
         assign st_in_data[s]  = in_data;
         assign st_in_shamt[s] = in_shamt;
         assign st_in_mode[s]  = norm_mode(in_mode);
         assign st_in_carry[s] = 1'b0;
      end else begin : g_next
         assign st_in_data[s]  = data_q[s-1];
         assign st_in_shamt[s] = shamt_q[s-1];
         assign st_in_mode[s]  = mode_q[s-1];
         assign st_in_carry[s] = carry_q[s-1];
      end
   end

   // Levels chain combinationally inside a stage; the first level of a stage reads the stage input.
   for (genvar k = 0; k < SHW; k++) begin : g_level
      localparam int ST    = stage_of_level(k, SHW, PIPE_STAGES);
      localparam bit FIRST = (k == 0) ? 1'b1 : (stage_of_level(k - 1, SHW, PIPE_STAGES) != ST);
      localparam bit LAST  = (k == SHW - 1) ? 1'b1 : (stage_of_level(k + 1, SHW, PIPE_STAGES) != ST);

      if (FIRST) begin : g_src_stage
         assign lvl_in_data[k]  = st_in_data[ST];
         assign lvl_in_carry[k] = st_in_carry[ST];
      end else begin : g_src_level
         assign lvl_in_data[k]  = lvl_out_data[k-1];
         assign lvl_in_carry[k] = lvl_out_carry[k-1];
      end

      shift_level #(.WIDTH(WIDTH), .K(k)) u_level (
         .data_in   (lvl_in_data[k]),
         .en        (st_in_shamt[ST][k]),
         .mode      (st_in_mode[ST]),
         .carry_in  (lvl_in_carry[k]),
         .data_out  (lvl_out_data[k]),
         .carry_out (lvl_out_carry[k])
      );

      if (LAST) begin : g_sink
         assign st_out_data[ST]  = lvl_out_data[k];
         assign st_out_carry[ST] = lvl_out_carry[k];
      end
   end

   // A stage may load when it or any stage after it has a hole, or the consumer takes the head.
   always_comb begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
         load[i] = out_ready;
         for (int j = i; j < PIPE_STAGES; j++) begin
            if (!valid_q[j]) load[i] = 1'b1;
         end
      end
      in_ready = load[0] && !flush;
   end

   always_comb begin
      valid_up = PIPE_STAGES'({valid_q, in_valid && in_ready});
      valid_d  = valid_q;
      zero_d   = zero_q;
      for (int i = 0; i < PIPE_STAGES; i++) begin
         data_d[i]  = data_q[i];
         shamt_d[i] = shamt_q[i];
         mode_d[i]  = mode_q[i];
         carry_d[i] = carry_q[i];
         if (load[i]) begin
            data_d[i]  = st_out_data[i];
            shamt_d[i] = st_in_shamt[i];
            mode_d[i]  = st_in_mode[i];
            carry_d[i] = st_out_carry[i];
            valid_d[i] = valid_up[i];
         end
      end
      if (load[PIPE_STAGES-1]) zero_d = (st_out_data[PIPE_STAGES-1] == '0);
      if (flush) valid_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         zero_q  <= 1'b0;
         for (int i = 0; i < PIPE_STAGES; i++) begin
            data_q[i]  <= '0;
            shamt_q[i] <= '0;
            mode_q[i]  <= '0;
            carry_q[i] <= 1'b0;
         end
      end else begin
         valid_q <= valid_d;
         zero_q  <= zero_d;
         for (int i = 0; i < PIPE_STAGES; i++) begin
            data_q[i]  <= data_d[i];
            shamt_q[i] <= shamt_d[i];
            mode_q[i]  <= mode_d[i];
            carry_q[i] <= carry_d[i];
         end
      end
   end

   assign out_valid = valid_q[PIPE_STAGES-1];
   assign out_data  = data_q[PIPE_STAGES-1];
   assign out_carry = carry_q[PIPE_STAGES-1];
   assign out_zero  = zero_q;

endmodule
